flag_intr_ctrl: RTL and testbench
=================================

# flag_intr_ctrl

Sequencer for the C/Z flag register in the RAT MCU, sitting between the control unit and the flag register. It passes control-unit flag requests through in normal execution. It also owns the interrupt-enable flag, the shadow C/Z flags and the interrupt pending latch. On interrupt it saves and clears C/Z and then acknowledges; on RETI it restores them.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- INTR  in  1  external interrupt request, level from I/O
- INSTR_DONE  in  1  control unit at an instruction boundary this cycle
- CU_C_SET, CU_C_CLR, CU_C_LD, CU_Z_LD  in  1 each  control-unit flag requests
- ALU_C, ALU_Z  in  1 each  ALU flag results
- CU_SEI, CU_CLI  in  1 each  set/clear interrupt enable
- CU_RETI  in  1  return from interrupt, one cycle
- CU_RETI_IE  in  1  I_FLAG value after RETI (1 = RETIE, 0 = RETID)
- C_FLAG, Z_FLAG  in  1 each  current flag register contents
- FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD  out  1 each  flag register controls
- C_IN, Z_IN  out  1 each  data to load into the flag register
- I_FLAG  out  1  interrupt enable
- INTR_ACK  out  1  one-cycle pulse; the control unit loads PC with 0x3FF and pushes PC
- SHAD_C, SHAD_Z  out  1 each  shadow flags

## Operation
- FSM states:
  - RUN: pass-through.
  - SAVE: one cycle.
  - ACK: one cycle.
- RUN outputs:
  - FLG_* = CU_*; C_IN = ALU_C, Z_IN = ALU_Z.
  - If CU_RETI: FLG_C_LD = 1, FLG_Z_LD = 1, C_IN = SHAD_C, Z_IN = SHAD_Z; I_FLAG <= CU_RETI_IE. CU_RETI overrides any CU_* flag request in the same cycle.
- Pending latch:
  - Set on a rising edge of the (synchronized) INTR while I_FLAG = 1.
  - Edges that arrive while I_FLAG = 0 are dropped.
  - CU_CLI clears pending.
- RUN -> SAVE when INSTR_DONE & pending & I_FLAG. The CU flag request on that cycle is still honoured.
- SAVE outputs:
  - SHAD_C <= C_FLAG, SHAD_Z <= Z_FLAG.
  - FLG_C_CLR = 1, FLG_Z_LD = 1 with Z_IN = 0.
  - I_FLAG <= 0; pending <= 0.
  - All CU_* inputs are ignored.
- ACK outputs:
  - INTR_ACK = 1; flag controls all 0.
  - CU_* ignored.
  - Next state is RUN.
- I_FLAG update priority, highest first: SAVE clear, CU_RETI, CU_CLI, CU_SEI.
- The flag register's own priority still applies to pass-through requests: CLR over SET over LD.

## Timing
- Reset values (asynchronous):
  - State = RUN; I_FLAG = 0; pending = 0.
  - SHAD_C = 0, SHAD_Z = 0; synchronizer/edge flops = 0.
  - INTR_ACK = 0; FLG_* follow RUN-state combinational rules.
- Pass-through outputs are combinational; there is zero added latency on flag writes.
- Interrupt entry: INSTR_DONE at edge n (state RUN) -> SAVE during cycle n+1 -> ACK during cycle n+2 -> RUN at n+3.
- A new INTR edge during SAVE/ACK is dropped, because I_FLAG is 0 from SAVE onward.
- RST mid-SAVE/ACK returns the FSM to RUN immediately. The shadow flags are cleared and no ACK is issued.
- Back-to-back: after RETIE, a pending interrupt can be taken at the next INSTR_DONE. A new INTR edge is needed to re-pend.

## Configuration
- FLAG_INTR_SYNC_EN defined:
  - INTR passes through a two-flop synchronizer before the edge detect.
  - An INTR rise sampled at edge k sets pending at edge k+2.
- Not defined:
  - INTR is treated as synchronous and edge-detected directly.
  - Pending is set at edge k.

## Structure
- Shared package flag_ctrl_pkg holds:
  - the state enum (RUN, SAVE, ACK);
  - the constant INTR_VECTOR = 10'h3FF, used by the control unit on INTR_ACK.
- Natural sub-module: intr_edge_sync, containing the optional synchronizer plus the rising-edge detector.
- FSM, pending latch, I_FLAG and shadow registers live in the top.

## Test plan
- Reset, then CU_C_SET = 1 -> FLG_C_SET = 1 the same cycle, I_FLAG = 0, INTR_ACK = 0.
- C_FLAG = 1, Z_FLAG = 1, CU_SEI, INTR rise, INSTR_DONE:
  - SAVE cycle: FLG_C_CLR = 1, FLG_Z_LD = 1, Z_IN = 0.
  - Next cycle: INTR_ACK = 1.
  - Afterwards: SHAD_C = 1, SHAD_Z = 1, I_FLAG = 0.
- Following RETI with CU_RETI_IE = 1 -> FLG_C_LD = FLG_Z_LD = 1, C_IN = 1, Z_IN = 1, I_FLAG = 1.
- INTR rise while I_FLAG = 0, then CU_SEI and INSTR_DONE -> no SAVE, INTR_ACK stays 0.
- INSTR_DONE with CU_Z_LD = 1, ALU_Z = 1 and pending -> Z pass-through that cycle, SAVE the next.
- RST asserted during SAVE -> RUN, I_FLAG = 0, SHAD_C = SHAD_Z = 0, no INTR_ACK.
- Both macro settings: pending set 2 cycles after the INTR sample vs 0 cycles.

Source files
------------

// File: rtl/flag_ctrl_pkg.sv
// Shared types and constants for the C/Z flag / interrupt sequencer.
// No logic; purely declarations.
// No flow control.
package flag_ctrl_pkg;

  // Sequencer states: pass-through, shadow save/clear, interrupt acknowledge.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Interrupt vector the control unit loads into PC on INTR_ACK.
  localparam logic [9:0] INTR_VECTOR = 10'h3FF;

endpackage

// File: rtl/intr_edge_sync.sv
// INTR rising-edge detector with optional two-flop synchronizer (FLAG_INTR_SYNC_EN).
// Latency: rise visible same cycle as INTR sample (unsynced) or two edges later (synced).
// No backpressure: a single-cycle pulse per rising edge.
module intr_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  output logic intr_rise
);

`ifdef FLAG_INTR_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift INTR through the synchronizer, then keep one more stage for edge detect.
  always_comb begin
    sync1_d = intr;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign intr_rise = sync2_q & ~prev_q;
`else
  logic prev_q, prev_d;

  // INTR is already synchronous: remember last sampled level.
  always_comb begin
    prev_d = intr;
  end

  // Previous INTR level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign intr_rise = intr & ~prev_q;
`endif

endmodule

// File: rtl/flag_intr_ctrl.sv
// C/Z flag sequencer: passes CU flag requests, saves/clears flags on interrupt, restores on RETI.
// Latency: pass-through is combinational; interrupt entry takes SAVE then ACK (2 cycles).
// No backpressure; INTR_ACK is a one-cycle pulse. Optional FLAG_INTR_SYNC_EN synchronizes INTR.
module flag_intr_ctrl
  import flag_ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  input  logic INSTR_DONE,
  input  logic CU_C_SET,
  input  logic CU_C_CLR,
  input  logic CU_C_LD,
  input  logic CU_Z_LD,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic CU_SEI,
  input  logic CU_CLI,
  input  logic CU_RETI,
  input  logic CU_RETI_IE,
  input  logic C_FLAG,
  input  logic Z_FLAG,
  output logic FLG_C_SET,
  output logic FLG_C_CLR,
  output logic FLG_C_LD,
  output logic FLG_Z_LD,
  output logic C_IN,
  output logic Z_IN,
  output logic I_FLAG,
  output logic INTR_ACK,
  output logic SHAD_C,
  output logic SHAD_Z
);

  state_t state_q, state_d;
  logic   i_flag_q, i_flag_d;
  logic   pending_q, pending_d;
  logic   shad_c_q, shad_c_d;
  logic   shad_z_q, shad_z_d;
  logic   intr_rise;

  intr_edge_sync u_edge (
    .clk       (CLK),
    .rst       (RST),
    .intr      (INTR),
    .intr_rise (intr_rise)
  );

  // Next-state, interrupt bookkeeping and flag-register controls.
  always_comb begin
    state_d   = state_q;
    i_flag_d  = i_flag_q;
    pending_d = pending_q;
    shad_c_d  = shad_c_q;
    shad_z_d  = shad_z_q;
    FLG_C_SET = 1'b0;
    FLG_C_CLR = 1'b0;
    FLG_C_LD  = 1'b0;
    FLG_Z_LD  = 1'b0;
    C_IN      = 1'b0;
    Z_IN      = 1'b0;
    INTR_ACK  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (CU_RETI) begin
          // Restore saved flags; overrides any concurrent CU flag request.
          FLG_C_LD = 1'b1;
          FLG_Z_LD = 1'b1;
          C_IN     = shad_c_q;
          Z_IN     = shad_z_q;
        end else begin
          FLG_C_SET = CU_C_SET;
          FLG_C_CLR = CU_C_CLR;
          FLG_C_LD  = CU_C_LD;
          FLG_Z_LD  = CU_Z_LD;
          C_IN      = ALU_C;
          Z_IN      = ALU_Z;
        end

        if (CU_RETI)     i_flag_d = CU_RETI_IE;
        else if (CU_CLI) i_flag_d = 1'b0;
        else if (CU_SEI) i_flag_d = 1'b1;

        // Edges seen while interrupts are disabled are simply lost.
        if (CU_CLI)                     pending_d = 1'b0;
        else if (intr_rise && i_flag_q) pending_d = 1'b1;

        // The CU request on the boundary cycle is honoured above.
        if (INSTR_DONE && pending_q && i_flag_q) state_d = ST_SAVE;
      end

      ST_SAVE: begin
        shad_c_d  = C_FLAG;
        shad_z_d  = Z_FLAG;
        FLG_C_CLR = 1'b1;
        FLG_Z_LD  = 1'b1;
        Z_IN      = 1'b0;
        i_flag_d  = 1'b0;
        pending_d = 1'b0;
        state_d   = ST_ACK;
      end

      ST_ACK: begin
        INTR_ACK = 1'b1;
        // I_FLAG is already 0 here, so no new edge can pend.
        if (intr_rise && i_flag_q) pending_d = 1'b1;
        state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  // State, interrupt-enable, pending latch and shadow flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_RUN;
      i_flag_q  <= 1'b0;
      pending_q <= 1'b0;
      shad_c_q  <= 1'b0;
      shad_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_flag_q  <= i_flag_d;
      pending_q <= pending_d;
      shad_c_q  <= shad_c_d;
      shad_z_q  <= shad_z_d;
    end
  end

  assign I_FLAG = i_flag_q;
  assign SHAD_C = shad_c_q;
  assign SHAD_Z = shad_z_q;

endmodule

// File: tb/tb_flag_intr_ctrl.sv
module tb_flag_intr_ctrl;

`ifdef FLAG_INTR_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic INTR = 0, INSTR_DONE = 0;
  logic CU_C_SET = 0, CU_C_CLR = 0, CU_C_LD = 0, CU_Z_LD = 0;
  logic ALU_C = 0, ALU_Z = 0, CU_SEI = 0, CU_CLI = 0, CU_RETI = 0, CU_RETI_IE = 0;
  logic C_FLAG = 0, Z_FLAG = 0;
  logic FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, C_IN, Z_IN;
  logic I_FLAG, INTR_ACK, SHAD_C, SHAD_Z;

  always #5 CLK = ~CLK;

  flag_intr_ctrl dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .INSTR_DONE(INSTR_DONE),
    .CU_C_SET(CU_C_SET), .CU_C_CLR(CU_C_CLR), .CU_C_LD(CU_C_LD), .CU_Z_LD(CU_Z_LD),
    .ALU_C(ALU_C), .ALU_Z(ALU_Z), .CU_SEI(CU_SEI), .CU_CLI(CU_CLI),
    .CU_RETI(CU_RETI), .CU_RETI_IE(CU_RETI_IE), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD),
    .C_IN(C_IN), .Z_IN(Z_IN), .I_FLAG(I_FLAG), .INTR_ACK(INTR_ACK),
    .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z)
  );

  typedef struct packed {
    logic c_set, c_clr, c_ld, z_ld, c_in, z_in, i_flag, ack, shad_c, shad_z;
  } obs_t;

  typedef struct {
    logic rst, intr, done, cs, cc, cl, zl, ac, az, sei, cli, reti, rie, cf, zf;
  } stim_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: int-coded phase counter (0 normal, 1 saving, 2 acknowledging),
  // plus a history of INTR levels sampled at each clock edge.
  int   m_phase;
  logic m_ie, m_pend, m_sc, m_sz;
  logic hist[$];

  function automatic void model_reset();
    m_phase = 0; m_ie = 0; m_pend = 0; m_sc = 0; m_sz = 0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
  endfunction

  // Advance the model over one clock edge, using the inputs held before the edge.
  function automatic void model_edge();
    logic rise;
    int   n;
    if (RST) begin
      model_reset();
      return;
    end
    hist.push_back(INTR);
    if (hist.size() > 8) void'(hist.pop_front());
    n = hist.size();
    rise = hist[n-1-DLY] & ~hist[n-2-DLY];
    if (m_phase == 1) begin
      m_sc = C_FLAG; m_sz = Z_FLAG; m_ie = 0; m_pend = 0; m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else begin
      logic go;
      go = INSTR_DONE & m_pend & m_ie;
      if (CU_CLI) m_pend = 0;
      else if (rise && m_ie) m_pend = 1;
      if (CU_RETI) m_ie = CU_RETI_IE;
      else if (CU_CLI) m_ie = 0;
      else if (CU_SEI) m_ie = 1;
      m_phase = go ? 1 : 0;
    end
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    if (m_phase == 1) begin
      o.c_clr = 1; o.z_ld = 1;
    end else if (m_phase == 2) begin
      o.ack = 1;
    end else if (CU_RETI) begin
      o.c_ld = 1; o.z_ld = 1; o.c_in = m_sc; o.z_in = m_sz;
    end else begin
      o.c_set = CU_C_SET; o.c_clr = CU_C_CLR; o.c_ld = CU_C_LD; o.z_ld = CU_Z_LD;
      o.c_in = ALU_C; o.z_in = ALU_Z;
    end
    o.i_flag = m_ie; o.shad_c = m_sc; o.shad_z = m_sz;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge CLK);
    model_edge();
    #1;
    RST = s.rst; INTR = s.intr; INSTR_DONE = s.done;
    CU_C_SET = s.cs; CU_C_CLR = s.cc; CU_C_LD = s.cl; CU_Z_LD = s.zl;
    ALU_C = s.ac; ALU_Z = s.az; CU_SEI = s.sei; CU_CLI = s.cli;
    CU_RETI = s.reti; CU_RETI_IE = s.rie; C_FLAG = s.cf; Z_FLAG = s.zf;
    if (RST) model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: every cycle the DUT presents a full output vector; compare with the queue head.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, C_IN, Z_IN,
             I_FLAG, INTR_ACK, SHAD_C, SHAD_Z};
        n_vec++;
        if (a !== e)begin
          n_bad++;
          $display("FAIL vec%0d {set,clr,cld,zld,cin,zin,ie,ack,sc,sz}: got %b expected %b",
                   n_vec, a, e);
        end
      end
    end
  end

  stim_t s;

  initial begin
    model_reset();
    s = '{default: 1'b0};
    // Reset, then a plain C set request.
    s.rst = 1; apply(s); apply(s);
    s.rst = 0; s.cs = 1; apply(s);
    s.cs = 0; apply(s);
    // Flags high, enable, INTR rise, wait for pending, then boundary with a Z load.
    s.cf = 1; s.zf = 1; s.sei = 1; apply(s);
    s.sei = 0; s.intr = 1; apply(s);
    repeat (3) apply(s);
    s.done = 1; s.zl = 1; s.az = 1; apply(s);
    s.done = 0; s.zl = 0; s.az = 0; s.cs = 1; apply(s);   // SAVE, CU ignored
    s.cs = 0; apply(s);                                    // ACK
    repeat (2) apply(s);
    // RETIE restores flags and re-enables.
    s.cf = 0; s.zf = 0; s.reti = 1; s.rie = 1; apply(s);
    s.reti = 0; s.rie = 0; s.done = 1; apply(s);           // no new edge: no SAVE
    s.done = 0; s.cli = 1; s.intr = 0; apply(s);
    // Edge while disabled is dropped even after a later enable.
    s.cli = 0; s.intr = 1; apply(s);
    repeat (3) apply(s);
    s.sei = 1; apply(s);
    s.sei = 0; s.done = 1; repeat (3) apply(s);
    // Enabled edge, take interrupt, reset in the middle of SAVE.
    s.done = 0; s.intr = 0; s.cf = 1; s.zf = 1; apply(s);
    s.intr = 1; repeat (4) apply(s);
    s.done = 1; apply(s);
    s.done = 0; s.rst = 1; apply(s);
    s.rst = 0; repeat (3) apply(s);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) s.intr = ~s.intr;
      s.done = ($urandom_range(0, 2) == 0);
      s.cs   = ($urandom_range(0, 3) == 0);
      s.cc   = ($urandom_range(0, 3) == 0);
      s.cl   = ($urandom_range(0, 3) == 0);
      s.zl   = ($urandom_range(0, 3) == 0);
      s.ac   = 1'($urandom);
      s.az   = 1'($urandom);
      s.sei  = ($urandom_range(0, 9) == 0);
      s.cli  = ($urandom_range(0, 39) == 0);
      s.reti = ($urandom_range(0, 24) == 0);
      s.rie  = 1'($urandom);
      s.cf   = 1'($urandom);
      s.zf   = 1'($urandom);
      apply(s);
    end
    s = '{default: 1'b0};
    apply(s);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
